program_writer: RTL and testbench



---
 rtl/program_writer_if.sv | 20 ++
 rtl/program_writer.sv | 72 +++++++
 tb/tb_program_writer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/program_writer_if.sv
// program_writer_if: instruction handshake in, RAM byte-write bus out.
interface program_writer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_opcode;
  logic [7:0]  in_reg;
  logic [15:0] in_operand;
  logic        in_last;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  modport master (
    output in_valid, in_opcode, in_reg, in_operand, in_last,
    input  in_ready, ram_we, ram_addr, ram_wdata
  );
  modport slave (
    input  in_valid, in_opcode, in_reg, in_operand, in_last,
    output in_ready, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/program_writer.sv
// program_writer: serialises decoded instructions into 4 consecutive RAM bytes.
module program_writer #(
  parameter int RAMSIZE = 64,
  parameter int BASE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  program_writer_if.slave  bus,
  output logic [7:0]       wpointer,
  output logic [7:0]       count,
  output logic             done,
  output logic             overflow
);
  typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, WR3, DONE} state_t;
  localparam logic [8:0] LIMIT = 9'(RAMSIZE - 4);
  state_t      state, nxt;
  logic [8:0]  wp;
  logic [7:0]  op_q, reg_q;
  logic [15:0] opd_q;
  logic        last_q, full, take, we;
  logic [1:0]  off;
  // pointer kept one bit wider so a RAMSIZE of 256 still reads as full
  assign full         = wp > LIMIT;
  assign bus.in_ready = state == IDLE && !full;
  assign take         = bus.in_ready && bus.in_valid;
  assign we           = state != IDLE && state != DONE;
  assign off          = 2'(state - WR0);
  assign bus.ram_we   = we;
  assign bus.ram_addr = we ? wp[7:0] + {6'd0, off} : '0;
  assign bus.ram_wdata = !we      ? '0 :
                         off == 0 ? op_q :
                         off == 1 ? reg_q :
                         off == 2 ? opd_q[7:0] : opd_q[15:8];
  assign wpointer = wp[7:0];
  assign done     = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = take ? WR0 : IDLE;
      WR0:     nxt = WR1;
      WR1:     nxt = WR2;
      WR2:     nxt = WR3;
      WR3:     nxt = last_q ? DONE : IDLE;
      default: nxt = state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wp       <= 9'(BASE);
      count    <= '0;
      overflow <= 1'b0;
      op_q     <= '0;
      reg_q    <= '0;
      opd_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      state <= nxt;
      if (take) begin
        op_q   <= bus.in_opcode;
        reg_q  <= bus.in_reg;
        opd_q  <= bus.in_operand;
        last_q <= bus.in_last;
      end
      if (state == IDLE && full && bus.in_valid) overflow <= 1'b1;
      if (state == WR3) begin
        wp    <= wp + 9'd4;
        count <= count + 8'(count != 8'hff);
      end
    end
  end
endmodule

// File: tb/tb_program_writer.sv
// tb_program_writer: random and directed stimulus against a transaction-level model.
module tb_program_writer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  program_writer_if m_if ();
  program_writer_if s_if ();
  logic [7:0] m_wp, m_cnt, s_wp, s_cnt;
  logic       m_done, m_ovf, s_done, s_ovf;
  program_writer #(.RAMSIZE(64), .BASE(0)) dut (
    .clk(clk), .reset(reset), .bus(m_if), .wpointer(m_wp), .count(m_cnt), .done(m_done), .overflow(m_ovf)
  );
  program_writer #(.RAMSIZE(8), .BASE(0)) dut_s (
    .clk(clk), .reset(reset), .bus(s_if), .wpointer(s_wp), .count(s_cnt), .done(s_done), .overflow(s_ovf)
  );
  assign s_if.in_valid   = m_if.in_valid;
  assign s_if.in_opcode  = m_if.in_opcode;
  assign s_if.in_reg     = m_if.in_reg;
  assign s_if.in_operand = m_if.in_operand;
  assign s_if.in_last    = m_if.in_last;
  logic [7:0] mem_m [256];
  logic [7:0] mem_s [256];
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_if.ram_we) mem_m[m_if.ram_addr] <= m_if.ram_wdata;
    if (s_if.ram_we) mem_s[s_if.ram_addr] <= s_if.ram_wdata;
  end
  int passed = 0, total = 0;
  int e_wp, e_cnt, s_acc;
  bit s_fin, s_ov;
  logic [7:0] exp_m [256];
  logic [7:0] exp_s [256];
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    else passed++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(int n);
    reset = 1'b1;
    m_if.in_valid = 1'b0;
    repeat (n) step();
    reset = 1'b0;
    e_wp = 0; e_cnt = 0; s_acc = 0; s_fin = 0; s_ov = 0;
  endtask
  task automatic send(logic [7:0] op, logic [7:0] rg, logic [15:0] opd, bit last, bit hold);
    logic [7:0] b [4];
    int t = 0;
    b = '{op, rg, opd[7:0], opd[15:8]};
    m_if.in_opcode = op; m_if.in_reg = rg; m_if.in_operand = opd; m_if.in_last = last;
    m_if.in_valid = 1'b1;
    while (!m_if.in_ready && t < 40) begin step(); t++; end
    if (!m_if.in_ready) begin
      chk("ready_wait", 0, 1);
      m_if.in_valid = 1'b0;
      return;
    end
    // the 8-byte instance holds two instructions, then refuses everything
    if (s_acc < 2 && !s_fin) begin
      for (int k = 0; k < 4; k++) exp_s[s_acc * 4 + k] = b[k];
      s_acc++;
      s_fin = last;
    end else if (!s_fin) s_ov = 1;
    step();
    if (!hold) m_if.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("ram_we", 32'(m_if.ram_we), 1);
      chk("ram_addr", 32'(m_if.ram_addr), e_wp + k);
      chk("ram_wdata", 32'(m_if.ram_wdata), 32'(b[k]));
      exp_m[e_wp + k] = b[k];
      step();
    end
    e_wp += 4;
    e_cnt++;
    chk("ready_after", 32'(m_if.in_ready), 32'(!last && e_wp <= 60));
    chk("wpointer", 32'(m_wp), e_wp);
    chk("count", 32'(m_cnt), e_cnt);
    chk("done", 32'(m_done), 32'(last));
  endtask
  task automatic check_small();
    int bad = 0;
    for (int i = 0; i < s_acc * 4; i++) if (mem_s[i] !== exp_s[i]) bad++;
    chk("small_mem", bad, 0);
    chk("small_wp", 32'(s_wp), s_acc * 4);
    chk("small_count", 32'(s_cnt), s_acc);
    chk("small_done", 32'(s_done), 32'(s_fin));
    chk("small_ovf", 32'(s_ovf), 32'(s_ov));
  endtask
  initial begin
    logic [7:0] prog [16];
    int c0, bad, gap;
    prog = '{2, 0, 16, 0, 2, 1, 17, 0, 4, 0, 1, 0, 3, 0, 18, 0};
    m_if.in_opcode = '0; m_if.in_reg = '0; m_if.in_operand = '0; m_if.in_last = 1'b0;
    reset = 1'b1;
    m_if.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("reset_we", 32'(m_if.ram_we), 0);
    end
    reset = 1'b0;
    chk("rst_ready", 32'(m_if.in_ready), 1);
    chk("rst_wp", 32'(m_wp), 0);
    chk("rst_count", 32'(m_cnt), 0);
    chk("rst_done", 32'(m_done), 0);
    chk("rst_ovf", 32'(m_ovf), 0);
    m_if.in_valid = 1'b0;
    e_wp = 0; e_cnt = 0; s_acc = 0; s_fin = 0; s_ov = 0;
    send(8'd2, 8'd0, 16'd16, 1'b0, 1'b0);
    do_reset(1);
    c0 = cyc;
    send(8'd2, 8'd0, 16'd16, 1'b0, 1'b1);
    send(8'd2, 8'd1, 16'd17, 1'b0, 1'b1);
    send(8'd4, 8'd0, 16'd1, 1'b0, 1'b1);
    send(8'd3, 8'd0, 16'd18, 1'b1, 1'b1);
    chk("prog_cycles", cyc - c0, 20);
    for (int i = 0; i < 16; i++) chk("prog_byte", 32'(mem_m[i]), 32'(prog[i]));
    m_if.in_opcode = 8'h77; m_if.in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("done_ready", 32'(m_if.in_ready), 0);
      chk("done_we", 32'(m_if.ram_we), 0);
      step();
    end
    m_if.in_valid = 1'b0;
    chk("done_ovf", 32'(m_ovf), 0);
    chk("done_count", 32'(m_cnt), 4);
    chk("done_sticky", 32'(m_done), 1);
    check_small();
    do_reset(2);
    send(8'h5c, 8'h3e, 16'ha55a, 1'b0, 1'b0);
    chk("a55a_lo", 32'(mem_m[2]), 32'h5a);
    chk("a55a_hi", 32'(mem_m[3]), 32'ha5);
    for (int n = 1; n < 10; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) step();
      send(8'($urandom), 8'($urandom), 16'($urandom), n == 9, 1'b0);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) if (mem_m[i] !== exp_m[i]) bad++;
    chk("rand_mem", bad, 0);
    chk("rand_count", 32'(m_cnt), 10);
    chk("rand_done", 32'(m_done), 1);
    chk("rand_ovf", 32'(m_ovf), 0);
    check_small();
    do_reset(1);
    m_if.in_opcode = 8'h11; m_if.in_reg = 8'h22; m_if.in_operand = 16'h4433; m_if.in_last = 1'b0;
    m_if.in_valid = 1'b1;
    step();
    m_if.in_valid = 1'b0;
    step();
    step();
    chk("abort_addr", 32'(m_if.ram_addr), 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_we", 32'(m_if.ram_we), 0);
    chk("abort_wp", 32'(m_wp), 0);
    chk("abort_count", 32'(m_cnt), 0);
    chk("abort_b0", 32'(mem_m[0]), 32'h11);
    chk("abort_b1", 32'(mem_m[1]), 32'h22);
    step();
    chk("abort_we2", 32'(m_if.ram_we), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
